// File: rtl/pio_pkg.sv
// Shared register map, STATUS bit positions and pulse-timer state encoding
// for the pio_out_pulse output port.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
  localparam logic [2:0] ADDR_PULSE     = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_IRQ_EN = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for pio_out_pulse.
// Zero-wait-state: a write is taken on every rising edge where chipselect is
// high and write_n low; readdata follows address in the same cycle, no waitrequest.
interface pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_pulse_timer.sv
// One-shot pulse timer: holds a mask for len clocks, retriggerable,
// with a sticky done flag that a pulse end sets and software clears.
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int PULSE_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       clear_done,
  input  logic [PULSE_CNT_WIDTH-1:0] len,
  input  logic [DATA_WIDTH-1:0]      mask,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_WIDTH-1:0]      mask_q,
  output pulse_state_e               state_o
);

  pulse_state_e               state_q, state_d;
  logic [PULSE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]      mask_d;
  logic                       done_q, done_d;
  logic                       start_ok;

  assign start_ok = start && (mask != '0) && (len != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  // The FSM assignments come after the software clear so a pulse end wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    done_d  = done_q;
    if (clear_done) done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = ACTIVE;
          cnt_d   = len;
          mask_d  = mask;
          done_d  = 1'b0;
        end
      end
      ACTIVE: begin
        if (start_ok) begin
          cnt_d  = len;
          mask_d = mask;
          done_d = 1'b0;
        end else if (cnt_q == PULSE_CNT_WIDTH'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - PULSE_CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == ACTIVE);
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with set/clear/toggle writes and a one-shot pulse
// that inverts masked output bits; level irq on sticky pulse-done.
module pio_out_pulse
  import pio_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int                    PULSE_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_out_pulse_if.slave        bus,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0]      data_out_q, data_out_d;
  logic [PULSE_CNT_WIDTH-1:0] pulse_len_q, pulse_len_d;
  logic                       irq_en_q, irq_en_d;

  logic                       wr;
  logic [DATA_WIDTH-1:0]      wd;
  logic                       pulse_start;
  logic                       clear_done;
  logic                       busy;
  logic                       done;
  logic [DATA_WIDTH-1:0]      mask_q;
  pulse_state_e               timer_state_unused;
  logic                       writedata_unused;

  assign wr               = bus.chipselect && !bus.write_n;
  assign wd               = bus.writedata[DATA_WIDTH-1:0];
  assign writedata_unused = ^bus.writedata;
  assign pulse_start      = wr && (bus.address == ADDR_PULSE);
  assign clear_done       = wr && (bus.address == ADDR_STATUS) && bus.writedata[STAT_DONE];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_q  <= RESET_VALUE;
      pulse_len_q <= '0;
      irq_en_q    <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      pulse_len_q <= pulse_len_d;
      irq_en_q    <= irq_en_d;
    end
  end

  always_comb begin
    data_out_d  = data_out_q;
    pulse_len_d = pulse_len_q;
    irq_en_d    = irq_en_q;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:      data_out_d  = wd;
        ADDR_SET:       data_out_d  = data_out_q | wd;
        ADDR_CLEAR:     data_out_d  = data_out_q & ~wd;
        ADDR_TOGGLE:    data_out_d  = data_out_q ^ wd;
        ADDR_PULSE_LEN: pulse_len_d = bus.writedata[PULSE_CNT_WIDTH-1:0];
        ADDR_STATUS:    irq_en_d    = bus.writedata[STAT_IRQ_EN];
        default:        ;
      endcase
    end
  end

  pio_pulse_timer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .PULSE_CNT_WIDTH (PULSE_CNT_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (pulse_start),
    .clear_done (clear_done),
    .len        (pulse_len_q),
    .mask       (wd),
    .busy       (busy),
    .done       (done),
    .mask_q     (mask_q),
    .state_o    (timer_state_unused)
  );

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:      bus.readdata[DATA_WIDTH-1:0]      = data_out_q;
      ADDR_PULSE_LEN: bus.readdata[PULSE_CNT_WIDTH-1:0] = pulse_len_q;
      ADDR_PULSE:     bus.readdata[DATA_WIDTH-1:0]      = mask_q;
      ADDR_STATUS: begin
        bus.readdata[STAT_BUSY]   = busy;
        bus.readdata[STAT_DONE]   = done;
        bus.readdata[STAT_IRQ_EN] = irq_en_q;
      end
      default: ;
    endcase
  end

  // Both operands are flops, so out_port has no path from the bus.
  assign out_port = data_out_q ^ (mask_q & {DATA_WIDTH{busy}});
  assign irq      = done & irq_en_q;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Bench for pio_out_pulse: register write/read tables, pulse timing,
// retrigger, ignored starts, reset abort and done set/clear collision.
module tb_pio_out_pulse;
  import pio_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [15:0] out_port;
  logic        irq;

  pio_out_pulse_if bus ();

  pio_out_pulse #(
    .DATA_WIDTH      (16),
    .RESET_VALUE     (16'hA5A5),
    .PULSE_CNT_WIDTH (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port),
    .irq      (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [15:0] exp_out;
  } wr_vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] exp_rd;
  } rd_vec_t;

  wr_vec_t wv[6];
  rd_vec_t rv[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard on out_port
  task automatic expect_out(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sample_out(input string name);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %h expected <empty queue>", name, out_port);
    end else begin
      e = exp_q.pop_front();
      check(name, {16'h0, out_port}, {16'h0, e});
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    check(name, bus.readdata, exp);
    bus.chipselect = 1'b0;
  endtask

  initial begin
    wv[0] = '{ADDR_DATA,   32'h0000_00F0, 16'h00F0};
    wv[1] = '{ADDR_SET,    32'h0000_0003, 16'h00F3};
    wv[2] = '{ADDR_CLEAR,  32'h0000_0010, 16'h00E3};
    wv[3] = '{ADDR_TOGGLE, 32'h0000_8001, 16'h80E2};
    wv[4] = '{3'd7,        32'h0000_FFFF, 16'h80E2};
    wv[5] = '{ADDR_SET,    32'hFFFF_0000, 16'h80E2};
    rv[0] = '{ADDR_DATA,   32'h0000_80E2};
    rv[1] = '{ADDR_SET,    32'h0};
    rv[2] = '{ADDR_CLEAR,  32'h0};
    rv[3] = '{ADDR_TOGGLE, 32'h0};
    rv[4] = '{3'd7,        32'h0};

    reset_n        = 1'b0;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    expect_out(16'hA5A5);
    sample_out("reset_out");
    check("reset_irq", {31'h0, irq}, 32'h0);
    rd("reset_status", ADDR_STATUS, 32'h0);

    // register write table, then read table
    for (int i = 0; i < 6; i++) begin
      expect_out(wv[i].exp_out);
      wr(wv[i].addr, wv[i].wdata);
      sample_out($sformatf("wr_vec%0d", i));
    end
    for (int i = 0; i < 5; i++) rd($sformatf("rd_vec%0d", i), rv[i].addr, rv[i].exp_rd);

    // basic pulse, length 5, irq enabled
    wr(ADDR_DATA, 32'h0);
    wr(ADDR_PULSE_LEN, 32'd5);
    wr(ADDR_STATUS, 32'h4);
    wr(ADDR_PULSE, 32'h000F);
    for (int i = 0; i < 5; i++) begin
      expect_out(16'h000F);
      sample_out($sformatf("pulse_on%0d", i));
      check("pulse_irq_low", {31'h0, irq}, 32'h0);
      rd("pulse_busy", ADDR_STATUS, 32'h5);
      tick();
    end
    expect_out(16'h0000);
    sample_out("pulse_off");
    check("pulse_irq_high", {31'h0, irq}, 32'h1);
    rd("pulse_done", ADDR_STATUS, 32'h6);
    wr(ADDR_STATUS, 32'h6);
    rd("done_cleared", ADDR_STATUS, 32'h4);
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // retrigger: len 4, mask 1 at t, mask 0x100 at t+3, ends after t+7
    wr(ADDR_PULSE_LEN, 32'd4);
    wr(ADDR_PULSE, 32'h0001);
    for (int i = 0; i < 3; i++) begin
      expect_out(16'h0001);
      sample_out($sformatf("retrig_a%0d", i));
      if (i < 2) tick();
    end
    wr(ADDR_PULSE, 32'h0100);
    for (int i = 0; i < 4; i++) begin
      expect_out(16'h0100);
      sample_out($sformatf("retrig_b%0d", i));
      rd("retrig_busy", ADDR_STATUS, 32'h5);
      tick();
    end
    expect_out(16'h0000);
    sample_out("retrig_end");
    rd("retrig_done", ADDR_STATUS, 32'h6);
    rd("retrig_mask", ADDR_PULSE, 32'h0100);

    // ignored starts: length 0, then mask 0; done stays set
    wr(ADDR_PULSE_LEN, 32'd0);
    wr(ADDR_PULSE, 32'h000F);
    expect_out(16'h0000);
    sample_out("len0_out");
    rd("len0_status", ADDR_STATUS, 32'h6);
    rd("len0_mask", ADDR_PULSE, 32'h0100);
    wr(ADDR_PULSE_LEN, 32'd3);
    wr(ADDR_PULSE, 32'h0000);
    expect_out(16'h0000);
    sample_out("mask0_out");
    rd("mask0_status", ADDR_STATUS, 32'h6);

    // reset in the middle of a pulse
    wr(ADDR_PULSE_LEN, 32'd10);
    wr(ADDR_PULSE, 32'h0003);
    tick();
    expect_out(16'h0003);
    sample_out("pre_reset_pulse");
    @(negedge clk);
    reset_n = 1'b0;
    tick();
    expect_out(16'hA5A5);
    sample_out("mid_reset_out");
    rd("mid_reset_status", ADDR_STATUS, 32'h0);
    rd("mid_reset_mask", ADDR_PULSE, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // pulse end and done-clear write on the same edge: done stays set
    wr(ADDR_PULSE_LEN, 32'd2);
    wr(ADDR_PULSE, 32'h0001);
    expect_out(16'hA5A4);
    sample_out("coll_on0");
    tick();
    expect_out(16'hA5A4);
    sample_out("coll_on1");
    wr(ADDR_STATUS, 32'h2);
    expect_out(16'hA5A5);
    sample_out("coll_off");
    rd("coll_done", ADDR_STATUS, 32'h2);
    check("coll_irq", {31'h0, irq}, 32'h0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
